multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle sequencer for the single-issue MIPS-subset datapath. It replaces the single-cycle combinational decode with a registered FSM that walks each instruction through fetch, decode, execute, memory and writeback, and handshakes with instruction and data memory that may stall. It drives every datapath enable, mux select and ALU operation, and keeps a retired-instruction counter.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instruction[31:26], valid from DECODE onward (IR registered)
- func  input  6  instruction[5:0]
- alu_zero  input  1  ALU zero flag, used in EXECUTE for BEQ
- im_ready  input  1  instruction memory has data this cycle
- dm_ready  input  1  data memory completes access this cycle
- im_req  output  1  instruction fetch request
- dm_req  output  1  data memory access request
- dm_we  output  1  data memory write enable (qualifies dm_req)
- ir_we  output  1  instruction register load
- pc_we  output  1  program counter load
- pc_src  output  2  0=PC+4, 1=branch target, 2=jump target
- rf_we  output  1  register file write enable
- reg_dst  output  1  0=rt, 1=rd
- mem_to_reg  output  1  0=ALU result, 1=memory data
- alu_src_b  output  1  0=register rt, 1=sign-extended immediate
- alu_op  output  4  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT
- illegal  output  1  one-cycle pulse: undefined opcode/func
- retired_count  output  CNT_W  completed instructions, wraps to 0

## Operation
- Supported: RTYPE 0x00 (func ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A), LW 0x23, SW 0x2B, ADDI 0x08, BEQ 0x04, J 0x02.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- FETCH: im_req=1. When im_ready=1: ir_we=1, pc_we=1, pc_src=0, -> DECODE. Otherwise stay; ir_we/pc_we stay 0.
- DECODE: J -> pc_we=1, pc_src=2, retire, -> FETCH. Illegal opcode or RTYPE with unknown func -> illegal=1, no other side effect, retire not counted, -> FETCH. All others -> EXECUTE.
- EXECUTE: alu_op/alu_src_b set per instruction (LW/SW/ADDI: ADD, imm; BEQ: SUB, reg; RTYPE: from func, reg). BEQ: pc_we=alu_zero, pc_src=1, retire, -> FETCH. LW/SW -> MEM. RTYPE/ADDI -> WRITEBACK.
- MEM: dm_req=1; dm_we=1 for SW only, held constant throughout. When dm_ready=1: SW retires -> FETCH; LW -> WRITEBACK. Otherwise stay.
- WRITEBACK: rf_we=1 for exactly one cycle; reg_dst=1 for RTYPE else 0; mem_to_reg=1 for LW. Retire, -> FETCH.
- Outputs not listed for a state are 0. alu_op held per instruction from DECODE through WRITEBACK.
- retired_count increments by 1 on each retire cycle; wraps 2^CNT_W-1 -> 0.

## Timing
- State register and retired_count update on rising clk; all strobes are combinational from state, opcode, func, alu_zero and ready inputs.
- Latency with ready inputs tied high: J 2, BEQ 3, RTYPE/ADDI 4, SW 4, LW 5 cycles.
- Each stall cycle (ready low) adds exactly one cycle; strobes dependent on ready assert only on the cycle ready=1. Ready asserted outside FETCH/MEM is ignored.
- Reset: while rst=1 all outputs 0, retired_count=0; next state FETCH. First cycle after rst deasserts: im_req=1.
- Reset mid-instruction (any state, incl. stalled MEM with dm_req high): next cycle is FETCH, no rf_we/pc_we/dm_we issued, partial instruction not counted.
- pc_we never asserts twice for one instruction except FETCH + (J or taken BEQ).

## Test plan
- Reset then ADD (0x00/0x20), im_ready=1 -> FETCH,DECODE,EXECUTE,WRITEBACK; rf_we=1 only in cycle 4, reg_dst=1, alu_op=0; retired_count=1.
- LW with dm_ready low 3 cycles -> dm_req=1,dm_we=0 for 4 MEM cycles, then WRITEBACK rf_we=1, mem_to_reg=1; 8 cycles total.
- BEQ alu_zero=1 -> pc_we=1,pc_src=1 in EXECUTE; alu_zero=0 -> pc_we=0; both 3 cycles, count +1 each.
- SW then J -> dm_we=1 in MEM only, no rf_we; J pc_we=1,pc_src=2 in DECODE; count +2.
- opcode 0x3F and RTYPE func 0x3F -> illegal pulse 1 cycle in DECODE, no enables, count unchanged, next FETCH.
- rst asserted during stalled MEM of SW -> next cycle FETCH, dm_req=0, retired_count=0; preset count 2^32-1 via retire sequence wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle FSM sequencer for the MIPS-subset datapath.
// Walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK and counts retired instructions.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             alu_zero,
    input  logic             im_ready,
    input  logic             dm_ready,
    output logic             im_req,
    output logic             dm_req,
    output logic             dm_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             rf_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_b,
    output logic [3:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEM, WRITEBACK
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             retire;
    logic             is_rtype, is_lw, is_sw, is_addi, is_beq, is_j;
    logic             rt_ok, legal;
    logic [3:0]       rt_op, dec_op;

    always_comb begin
        is_rtype = (opcode == 6'h00);
        is_lw    = (opcode == 6'h23);
        is_sw    = (opcode == 6'h2B);
        is_addi  = (opcode == 6'h08);
        is_beq   = (opcode == 6'h04);
        is_j     = (opcode == 6'h02);
        rt_ok    = 1'b1;
        rt_op    = OP_ADD;
        case (func)
            6'h20:   rt_op = OP_ADD;
            6'h22:   rt_op = OP_SUB;
            6'h24:   rt_op = OP_AND;
            6'h25:   rt_op = OP_OR;
            6'h2A:   rt_op = OP_SLT;
            default: rt_ok = 1'b0;
        endcase
        legal = (is_rtype && rt_ok) || is_lw || is_sw
              || is_addi || is_beq || is_j;
        dec_op = OP_ADD;
        unique case (1'b1)
            is_rtype: dec_op = rt_op;
            is_beq:   dec_op = OP_SUB;
            default:  dec_op = OP_ADD;
        endcase
    end

    always_comb begin
        state_nx   = state;
        retire     = 1'b0;
        im_req     = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        rf_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = OP_ADD;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                im_req = 1'b1;
                if (im_ready) begin
                    ir_we    = 1'b1;
                    pc_we    = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                if (!legal) begin
                    illegal  = 1'b1;
                    state_nx = FETCH;
                end else if (is_j) begin
                    pc_we    = 1'b1;
                    pc_src   = 2'd2;
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else begin
                    alu_op   = dec_op;
                    state_nx = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_op    = dec_op;
                alu_src_b = is_lw || is_sw || is_addi;
                if (is_beq) begin
                    pc_we    = alu_zero;
                    pc_src   = 2'd1;
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else if (is_lw || is_sw) begin
                    state_nx = MEM;
                end else begin
                    state_nx = WRITEBACK;
                end
            end
            MEM: begin
                alu_op = dec_op;
                dm_req = 1'b1;
                dm_we  = is_sw;
                if (dm_ready) begin
                    retire   = is_sw;
                    state_nx = is_sw ? FETCH : WRITEBACK;
                end
            end
            WRITEBACK: begin
                alu_op     = dec_op;
                rf_we      = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
                retire     = 1'b1;
                state_nx   = FETCH;
            end
            default: state_nx = FETCH;
        endcase
        // Reset overrides every strobe so a half-done instruction has no effect
        if (rst) begin
            retire     = 1'b0;
            im_req     = 1'b0;
            dm_req     = 1'b0;
            dm_we      = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            pc_src     = 2'd0;
            rf_we      = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_b  = 1'b0;
            alu_op     = OP_ADD;
            illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (retire)
                cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign retired_count = rst ? '0 : cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Counter is narrowed to 4 bits so the wrap is reachable.
module tb_multicycle_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [5:0]       opcode = '0;
    logic [5:0]       func = '0;
    logic             alu_zero = 1'b0;
    logic             im_ready = 1'b0;
    logic             dm_ready = 1'b0;
    logic             im_req, dm_req, dm_we, ir_we, pc_we;
    logic [1:0]       pc_src;
    logic             rf_we, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0]       alu_op;
    logic             illegal;
    logic [CNT_W-1:0] retired_count;
    logic [15:0]      obs;

    int         tests = 0;
    int         failed = 0;
    logic [3:0] exp_cnt = '0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_fn = '0;
    logic       cur_rst = 1'b1;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func),
        .alu_zero(alu_zero), .im_ready(im_ready), .dm_ready(dm_ready),
        .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    assign obs = {im_req, dm_req, dm_we, ir_we, pc_we, pc_src, rf_we,
                  reg_dst, mem_to_reg, alu_src_b, alu_op, illegal};

    function automatic logic [15:0] v(
        input logic im, dm, we, ir, pcw,
        input logic [1:0] src,
        input logic rf, rd, m2r, sb,
        input logic [3:0] op,
        input logic ill);
        return {im, dm, we, ir, pcw, src, rf, rd, m2r, sb, op, ill};
    endfunction

    // Apply one cycle of inputs at negedge; outputs are checked 1ns later
    task automatic cyc(input logic imr, input logic dmr, input logic z);
        @(negedge clk);
        rst      = cur_rst;
        opcode   = cur_op;
        func     = cur_fn;
        im_ready = imr;
        dm_ready = dmr;
        alu_zero = z;
        #1;
    endtask

    task automatic test_reset();
        cur_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 1);
            tests++;
            if (obs !== 16'h0) begin
                failed++;
                $display("FAIL reset_out c%0d got %h want 0000", i, obs);
            end
            tests++;
            if (retired_count !== 4'd0) begin
                failed++;
                $display("FAIL reset_cnt c%0d got %0d want 0", i, retired_count);
            end
        end
        cur_rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_add();
        logic [15:0] e [4];
        e = '{v(1,0,0,1,1,0,0,0,0,0,0,0), 16'h0, 16'h0,
              v(0,0,0,0,0,0,1,1,0,0,0,0)};
        cur_op = 6'h00;
        cur_fn = 6'h20;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL add c%0d got %h want %h", i, obs, e[i]);
            end
        end
        exp_cnt++;
        cyc(0, 1, 0);
        tests++;
        if (obs !== 16'h8000 || retired_count !== exp_cnt) begin
            failed++;
            $display("FAIL add_end got %h/%0d want 8000/%0d",
                     obs, retired_count, exp_cnt);
        end
    endtask

    task automatic test_rtype_ops();
        logic [5:0]  fns [4];
        logic [15:0] e [4];
        fns = '{6'h22, 6'h24, 6'h25, 6'h2A};
        cur_op = 6'h00;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] op;
            op = 4'(k + 1);
            cur_fn = fns[k];
            e = '{v(1,0,0,1,1,0,0,0,0,0,0,0), v(0,0,0,0,0,0,0,0,0,0,op,0),
                  v(0,0,0,0,0,0,0,0,0,0,op,0), v(0,0,0,0,0,0,1,1,0,0,op,0)};
            for (int i = 0; i < 4; i++) begin
                cyc(1, 0, 0);
                tests++;
                if (obs !== e[i]) begin
                    failed++;
                    $display("FAIL rtype f%h c%0d got %h want %h",
                             fns[k], i, obs, e[i]);
                end
            end
            exp_cnt++;
        end
        cyc(0, 0, 0);
        tests++;
        if (retired_count !== exp_cnt) begin
            failed++;
            $display("FAIL rtype_cnt got %0d want %0d", retired_count, exp_cnt);
        end
    endtask

    task automatic test_lw_stall();
        logic [15:0] e [8];
        e = '{v(1,0,0,1,1,0,0,0,0,0,0,0), 16'h0, v(0,0,0,0,0,0,0,0,0,1,0,0),
              v(0,1,0,0,0,0,0,0,0,0,0,0), v(0,1,0,0,0,0,0,0,0,0,0,0),
              v(0,1,0,0,0,0,0,0,0,0,0,0), v(0,1,0,0,0,0,0,0,0,0,0,0),
              v(0,0,0,0,0,0,1,0,1,0,0,0)};
        cur_op = 6'h23;
        cur_fn = 6'h3F;
        for (int i = 0; i < 8; i++) begin
            cyc(1, (i < 3 || i > 5), 0);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL lw c%0d got %h want %h", i, obs, e[i]);
            end
        end
        exp_cnt++;
        cyc(0, 0, 0);
        tests++;
        if (obs !== 16'h8000 || retired_count !== exp_cnt) begin
            failed++;
            $display("FAIL lw_end got %h/%0d want 8000/%0d",
                     obs, retired_count, exp_cnt);
        end
    endtask

    task automatic test_addi();
        logic [15:0] e [4];
        e = '{v(1,0,0,1,1,0,0,0,0,0,0,0), 16'h0,
              v(0,0,0,0,0,0,0,0,0,1,0,0), v(0,0,0,0,0,0,1,0,0,0,0,0)};
        cur_op = 6'h08;
        cur_fn = 6'h22;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL addi c%0d got %h want %h", i, obs, e[i]);
            end
        end
        exp_cnt++;
    endtask

    task automatic test_beq();
        logic [15:0] e [3];
        cur_op = 6'h04;
        cur_fn = 6'h00;
        for (int z = 1; z >= 0; z--) begin
            e = '{v(1,0,0,1,1,0,0,0,0,0,0,0), v(0,0,0,0,0,0,0,0,0,0,1,0),
                  v(0,0,0,0,1'(z),1,0,0,0,0,1,0)};
            for (int i = 0; i < 3; i++) begin
                cyc(1, 1, 1'(z));
                tests++;
                if (obs !== e[i]) begin
                    failed++;
                    $display("FAIL beq z%0d c%0d got %h want %h", z, i, obs, e[i]);
                end
            end
            exp_cnt++;
        end
        cyc(0, 0, 0);
        tests++;
        if (obs !== 16'h8000 || retired_count !== exp_cnt) begin
            failed++;
            $display("FAIL beq_end got %h/%0d want 8000/%0d",
                     obs, retired_count, exp_cnt);
        end
    endtask

    task automatic test_sw_j();
        logic [15:0] e [6];
        e = '{v(1,0,0,1,1,0,0,0,0,0,0,0), 16'h0, v(0,0,0,0,0,0,0,0,0,1,0,0),
              v(0,1,1,0,0,0,0,0,0,0,0,0),
              v(1,0,0,1,1,0,0,0,0,0,0,0), v(0,0,0,0,1,2,0,0,0,0,0,0)};
        cur_fn = 6'h20;
        for (int i = 0; i < 6; i++) begin
            cur_op = (i < 4) ? 6'h2B : 6'h02;
            cyc(1, 1, 1);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL sw_j c%0d got %h want %h", i, obs, e[i]);
            end
        end
        exp_cnt += 4'd2;
        cyc(0, 0, 0);
        tests++;
        if (obs !== 16'h8000 || retired_count !== exp_cnt) begin
            failed++;
            $display("FAIL sw_j_end got %h/%0d want 8000/%0d",
                     obs, retired_count, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        ops = '{6'h3F, 6'h00};
        fns = '{6'h20, 6'h3F};
        for (int k = 0; k < 2; k++) begin
            cur_op = ops[k];
            cur_fn = fns[k];
            cyc(1, 1, 1);
            cyc(1, 1, 1);
            tests++;
            if (obs !== v(0,0,0,0,0,0,0,0,0,0,0,1)) begin
                failed++;
                $display("FAIL illegal k%0d decode got %h want 0001", k, obs);
            end
            cyc(0, 1, 1);
            tests++;
            if (obs !== 16'h8000 || retired_count !== exp_cnt) begin
                failed++;
                $display("FAIL illegal k%0d next got %h/%0d want 8000/%0d",
                         k, obs, retired_count, exp_cnt);
            end
        end
    endtask

    task automatic test_mid_reset();
        cur_op = 6'h2B;
        cur_fn = 6'h00;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0);
            tests++;
            if (obs !== v(0,1,1,0,0,0,0,0,0,0,0,0)) begin
                failed++;
                $display("FAIL midrst stall c%0d got %h want 6000", i, obs);
            end
        end
        cur_rst = 1'b1;
        cyc(1, 1, 0);
        tests++;
        if (obs !== 16'h0 || retired_count !== 4'd0) begin
            failed++;
            $display("FAIL midrst during got %h/%0d want 0000/0", obs, retired_count);
        end
        cur_rst = 1'b0;
        exp_cnt = '0;
        cyc(0, 1, 0);
        tests++;
        if (obs !== 16'h8000 || retired_count !== 4'd0) begin
            failed++;
            $display("FAIL midrst after got %h/%0d want 8000/0", obs, retired_count);
        end
    endtask

    task automatic test_wrap();
        cur_op = 6'h02;
        cur_fn = 6'h00;
        for (int n = 0; n < 15; n++) begin
            cyc(1, 0, 0);
            cyc(1, 0, 0);
            exp_cnt++;
        end
        cyc(0, 0, 0);
        tests++;
        if (retired_count !== 4'd15 || exp_cnt !== 4'd15) begin
            failed++;
            $display("FAIL wrap_max got %0d want 15", retired_count);
        end
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        exp_cnt++;
        cyc(0, 0, 0);
        tests++;
        if (retired_count !== 4'd0) begin
            failed++;
            $display("FAIL wrap_zero got %0d want 0", retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_rtype_ops();
        test_lw_stall();
        test_addi();
        test_beq();
        test_sw_j();
        test_illegal();
        test_mid_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
